mem_wb_stage: RTL
=================

# mem_wb_stage

Owns the MEM/WB pipeline register and the data-cache request/response handshake between the memory stage and register-file writeback. Gates the memory stage's combinational dmem request into a single-cycle pulse, stalls upstream until the cache responds, aligns and sign-extends load data, and drives the register-file write port and commit counter. Sits directly downstream of the memory stage and upstream of the register file.

## Interface
- No parameters; widths come from `rv32i_types`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `mem_wb_reg_next` holds a real instruction.
- `mem_wb_reg_next` in `mem_wb_reg_t`: memory-stage output.
- `dmem_read_req` / `dmem_write_req` in 1: memory-stage raw request.
- `dmem_resp` in 1: cache done (read data valid or write accepted).
- `dmem_rdata` in 32: cache read word.
- `dmem_read` / `dmem_write` out 1: gated request to cache.
- `stall` out 1: freeze IF..EX/MEM pipeline registers.
- `mem_wb_reg` out `mem_wb_reg_t`: registered MEM/WB contents.
- `wb_valid` out 1: `mem_wb_reg` is a real instruction.
- `rd_we` out 1, `rd_addr` out 5, `rd_wdata` out 32: register-file write port.
- `commit_order` out 64: count of retired instructions.

## Operation
- FSM `IDLE`, `WAIT_RESP`.
- `mem_op = in_valid && (dmem_read_req || dmem_write_req)`.
- In `IDLE`:
  - `dmem_read = in_valid && dmem_read_req`; likewise for write.
  - If `mem_op`, go to `WAIT_RESP`.
- In `WAIT_RESP`:
  - `dmem_read` and `dmem_write` are 0; the request is never reissued.
  - Stay until `dmem_resp`, then return to `IDLE`.
- `stall = (IDLE && mem_op) || (WAIT_RESP && !dmem_resp)`.
- Register update each edge:
  - When `stall`: `wb_valid <= 0` (bubble); `mem_wb_reg` holds.
  - Else: `mem_wb_reg <= mem_wb_reg_next` and `wb_valid <= in_valid`.
  - On the response cycle, `mem_wb_reg.mem_rdata <= dmem_rdata`.
- Load alignment uses `funct3 = instruction[14:12]` and `off = mem_addr` low bits taken from `alu_out[1:0]`:
  - LB and LBU take byte `off`, sign- or zero-extended.
  - LH and LHU take half `off[1]`, sign- or zero-extended.
  - LW takes the whole word.
- `rd_wdata` selects on `cntrl_sigs.wb_sel`:
  - `WB_ALU` gives `alu_out`.
  - `WB_CMP` gives `{31'b0, cmp_out}`.
  - `WB_UIMM` gives `u_imm`.
  - `WB_PC4` gives `pcplus4`.
  - `WB_MEM` gives the aligned load.
- `rd_we = wb_valid && cntrl_sigs.regf_we && rd_addr != 0`.
- `rd_addr = mem_wb_reg.rd_addr`.
- `commit_order` increments by 1 on every cycle with `wb_valid`.
- A `dmem_resp` seen in `IDLE` (stray) is ignored.

## Timing
- Reset value of every output:
  - `wb_valid = 0`, `rd_we = 0`.
  - `mem_wb_reg = '0`, `commit_order = 0`.
  - FSM state = `IDLE`.
  - `dmem_read`, `dmem_write` and `stall` follow their combinational equations from `IDLE`.
- Non-memory instruction: present in cycle N, so `wb_valid`/`rd_we` go high in N+1.
- Memory instruction:
  - Request pulse and `stall = 1` in cycle N.
  - `dmem_resp` arrives earliest in N+1, at cycle N+k.
  - `stall = 0` in N+k; the write-back occurs in N+k+1.
- Same-cycle response in cycle N is not supported; the cache guarantees k ≥ 1.
- Upstream holds `mem_wb_reg_next` and the request inputs stable while `stall` is high.
- Back-to-back memory ops: the next request issues in cycle N+k+1 at the earliest.
- Reset mid-`WAIT_RESP`: state returns to `IDLE` immediately.
  - The in-flight instruction is dropped.
  - A late `dmem_resp` after reset is ignored.

## Structure
- Add to `rv32i_types`:
  - enum `wb_sel_t` (`WB_ALU`, `WB_CMP`, `WB_UIMM`, `WB_PC4`, `WB_MEM`).
  - `wb_sel` and `regf_we` fields in the control-signal struct.
  - enum `load_funct3_t` (LB=000, LH=001, LW=010, LBU=100, LHU=101).
- One sub-module, `load_aligner`: combinational, taking funct3, offset and rdata and producing a 32-bit result. It is reused by future forwarding logic.

## Test plan
- ALU op, `rd=5`, `alu_out=0x1234`, no memory access:
  - Next cycle `rd_we=1`, `rd_wdata=0x1234`.
  - `commit_order` goes 0→1.
  - `stall` is never asserted.
- LW, `alu_out=0x100`, `dmem_resp` 3 cycles later with `rdata=0xDEADBEEF`:
  - `dmem_read` high for exactly one cycle.
  - `stall` high for 3 cycles.
  - `rd_wdata=0xDEADBEEF` one cycle after the response.
- LB and LBU, `alu_out=0x103`, `rdata=0x80FF_FFFF`:
  - LB gives `0xFFFFFF80`.
  - LBU gives `0x00000080`.
- LH and LHU, `off=2`, `rdata=0x8001_0000`:
  - LH gives `0xFFFF8001`.
  - LHU gives `0x00008001`.
- SW followed by an ALU op:
  - One write pulse; no `rd_we` for the store.
  - The ALU op writes back after the store's response.
  - `commit_order` advances by 2.
- Assert `rst_n=0` during `WAIT_RESP`, then release and send a stray `dmem_resp`:
  - All outputs at reset values.
  - Stray response ignored; no write.
  - `commit_order` stays 0.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I pipeline types for the MEM/WB stage and its load aligner
package rv32i_types;
  typedef enum logic [2:0] {
    WB_ALU  = 3'd0,
    WB_CMP  = 3'd1,
    WB_UIMM = 3'd2,
    WB_PC4  = 3'd3,
    WB_MEM  = 3'd4
  } wb_sel_t;
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;
  typedef struct packed {
    wb_sel_t wb_sel;
    logic    regf_we;
  } cntrl_sigs_t;
  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pcplus4;
    logic [31:0] alu_out;
    logic [31:0] u_imm;
    logic [31:0] mem_rdata;
    logic [4:0]  rd_addr;
    logic        cmp_out;
    cntrl_sigs_t cntrl_sigs;
  } mem_wb_reg_t;
endpackage

// File: rtl/mem_wb_stage_load_aligner.sv
// load_aligner: extracts and extends the addressed byte/half/word of a load
module load_aligner
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];
  // select the extension by load width and signedness; anything else is a full word
  always_comb
    result = funct3 == LB  ? {{24{b[7]}}, b} :
             funct3 == LBU ? {24'b0, b} :
             funct3 == LH  ? {{16{h[15]}}, h} :
             funct3 == LHU ? {16'b0, h} : rdata;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB register, one-shot dmem handshake, load alignment and writeback
module mem_wb_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  mem_wb_reg_t mem_wb_reg_next,
  input  logic        dmem_read_req,
  input  logic        dmem_write_req,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        stall,
  output mem_wb_reg_t mem_wb_reg,
  output logic        wb_valid,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic [63:0] commit_order
);
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_RESP = 1'b1;
  logic [0:0]  state;
  logic        idle, mem_op, resp;
  logic [31:0] load_data;
  assign idle       = state == IDLE;
  assign mem_op     = in_valid && (dmem_read_req || dmem_write_req);
  assign resp       = !idle && dmem_resp;
  assign dmem_read  = idle && in_valid && dmem_read_req;
  assign dmem_write = idle && in_valid && dmem_write_req;
  assign stall      = idle ? mem_op : !dmem_resp;
  // request issues once from IDLE; a response seen in IDLE is stray and ignored
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else if (idle && mem_op) state <= WAIT_RESP;
    else if (resp) state <= IDLE;
  // pipeline register: bubble while stalled, capture load data on the response cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_wb_reg   <= '0;
      wb_valid     <= 1'b0;
      commit_order <= '0;
    end else begin
      wb_valid     <= !stall && in_valid;
      commit_order <= commit_order + 64'(wb_valid);
      if (!stall) begin
        mem_wb_reg <= mem_wb_reg_next;
        if (resp) mem_wb_reg.mem_rdata <= dmem_rdata;
      end
    end
  load_aligner u_load_aligner (
    .funct3(mem_wb_reg.instruction[14:12]),
    .off   (mem_wb_reg.alu_out[1:0]),
    .rdata (mem_wb_reg.mem_rdata),
    .result(load_data)
  );
  assign rd_addr = mem_wb_reg.rd_addr;
  assign rd_we   = wb_valid && mem_wb_reg.cntrl_sigs.regf_we && rd_addr != 5'd0;
  // writeback source mux
  always_comb
    rd_wdata = mem_wb_reg.cntrl_sigs.wb_sel == WB_ALU  ? mem_wb_reg.alu_out :
               mem_wb_reg.cntrl_sigs.wb_sel == WB_CMP  ? {31'b0, mem_wb_reg.cmp_out} :
               mem_wb_reg.cntrl_sigs.wb_sel == WB_UIMM ? mem_wb_reg.u_imm :
               mem_wb_reg.cntrl_sigs.wb_sel == WB_PC4  ? mem_wb_reg.pcplus4 : load_data;
endmodule
